mips_mc_control: RTL
====================

# mips_mc_control

Multi-cycle control FSM for the MIPS datapath. It is the issuing end of the ALU interface: it decodes the instruction word into the 4-bit ALU opcode and operand selects, and consumes the ALU Z/N flags to resolve branches. It also sequences fetch, decode, execute, memory and write-back, and drives every datapath strobe (IR, PC, memory, register file).

## Interface
Parameters:
- none. All encodings are fixed constants in `mips_ctrl_pkg`.

Ports:
- `clk`  in  1  system clock. One clock domain; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous reset, active-low.
- `instr`  in  32  instruction word from memory. Sampled only in FETCH while `mem_ready`=1.
- `mem_ready`  in  1  memory completes the current read or write this cycle.
- `z`  in  1  ALU zero flag. Combinational from the `alu_op` driven this cycle.
- `n`  in  1  ALU negative flag (Out[31]).
- `alu_op`  out  4  ALU opcode:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR;
  - 6 SLL (A<<B), 7 SRL, 8 SRA, 9 SLT (unsigned A<B);
  - A PASSA, B PASSB, C B+8.
- `alu_src_a`  out  2  A operand select: 0 rs, 1 rt, 2 zero-extended imm16.
- `alu_src_b`  out  3  B operand select: 0 rt, 1 sign-extended imm16, 2 zero-extended imm16, 3 shamt, 4 constant 16, 5 latched PC.
- `ir_write`  out  1  load the instruction register.
- `pc_write`  out  1  load the PC.
- `pc_src`  out  2  PC source: 0 PC+4, 1 branch target, 2 jump target, 3 rs.
- `mem_rd`  out  1  memory read request.
- `mem_wr`  out  1  memory write request.
- `reg_write`  out  1  register-file write enable.
- `reg_dst`  out  2  destination register: 0 rt, 1 rd, 2 r31.
- `mem_to_reg`  out  1  write-back data select: 1 memory data, 0 ALU result.
- `illegal`  out  1  one-cycle pulse on an undecodable instruction.
- `state`  out  3  current state, for debug.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP.
- FETCH:
  - `mem_rd`=1 every cycle in this state.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=0; latch opcode, funct and rt field internally; go to DECODE.
  - Otherwise hold in FETCH with all other strobes 0.
- DECODE selects the next state:
  - R-type ALU ops and I-type ALU ops → EXEC.
  - lw/sw → EXEC.
  - beq/bne/blez/bgtz → BRANCH.
  - j/jal/jr/jalr → JUMP.
  - Anything else: `illegal`=1 for this cycle only, then FETCH.
- R-type funct → `alu_op`:
  - 20/21 → ADD, 22/23 → SUB, 24 → AND, 25 → OR, 26 → XOR, 27 → NOR.
  - 2A/2B → SLT. Signed and unsigned both map to SLT.
  - 00/02/03 → SLL/SRL/SRA with `alu_src_a`=1, `alu_src_b`=3.
- I-type opcode → `alu_op`:
  - 08/09 → ADD with sign-extended imm.
  - 0A/0B → SLT with sign-extended imm.
  - 0C/0D/0E → AND/OR/XOR with zero-extended imm.
  - 0F lui → SLL with A = zero-extended imm, B = 16.
  - 23 lw / 2B sw → ADD with sign-extended imm.
- EXEC: drive `alu_op` and selects. Next state is MEM for lw/sw, WB otherwise.
- MEM:
  - lw: `mem_rd`=1.
  - sw: `mem_wr`=1.
  - Hold until `mem_ready`=1. Then lw → WB, sw → FETCH.
- WB: `reg_write`=1 for one cycle, then FETCH.
  - `reg_dst`: 1 for R-type, 0 for I-type.
  - `mem_to_reg`: 1 only for lw.
  - `alu_op` and selects are held at their EXEC values.
- BRANCH:
  - beq/bne: `alu_op`=SUB with rs, rt.
  - blez/bgtz: `alu_op`=PASSA with rs.
  - Taken conditions: beq Z; bne !Z; blez Z|N; bgtz !Z&!N.
  - If taken: `pc_write`=1, `pc_src`=1. Always go to FETCH.
- JUMP: `pc_write`=1.
  - j/jal use `pc_src`=2; jr/jalr use `pc_src`=3.
  - jal/jalr also drive `alu_op`=C with `alu_src_b`=5 and `reg_write`=1. `reg_dst` is 2 for jal and 1 for jalr.
  - Always go to FETCH.
- Outputs not named for a state are 0. `alu_op` defaults to 0.

## Timing
- Reset (asynchronous, immediate):
  - state = FETCH; latched fields = 0.
  - All strobes = 0 except `mem_rd`=1, which follows from FETCH.
  - `alu_op`=0, `illegal`=0.
- Strobes are Moore-decoded from state plus latched fields, except the FETCH/MEM `mem_ready` qualification and the BRANCH flag use, which are same-cycle.
- Cycles with zero wait states:
  - ALU ops: 4 (FETCH, DECODE, EXEC, WB).
  - lw: 5.
  - sw: 4.
  - Branches and jumps: 3.
- Each memory wait cycle adds one cycle in FETCH or MEM.
- `mem_ready` is ignored outside FETCH and MEM.
- Reset asserted mid-instruction aborts it with no write strobe. After reset release, the first edge with `mem_ready`=1 is the first fetch.

## Structure
- `mips_ctrl_pkg` contains:
  - ALU opcode constants (values above);
  - opcode and funct constants;
  - state enum;
  - the encodings for `alu_src_a`, `alu_src_b`, `pc_src` and `reg_dst`.
- Sub-module `alu_op_decoder` is combinational. It maps {opcode, funct} → {`alu_op`, `alu_src_a`, `alu_src_b`, legal}.
- The FSM lives in `mips_mc_control`.

## Test plan
- Reset with `mem_ready`=1 and instr=add r3,r1,r2 (0x00221820): `ir_write` at cycle 0; EXEC `alu_op`=0; WB `reg_write`=1 with `reg_dst`=1; back in FETCH at cycle 4.
- lw r5,8(r4) (0x8C850008) with `mem_ready` low for 2 MEM cycles: EXEC `alu_op`=0 and `alu_src_b`=1; `mem_rd` held 3 cycles; WB has `mem_to_reg`=1 and `reg_dst`=0; 7 cycles total.
- beq r1,r2 (0x10220004): with z=1, BRANCH gives `pc_write`=1 and `pc_src`=1. With z=0, `pc_write`=0. Both cases reach FETCH after 3 cycles.
- bgtz r1 (0x1C200002): n=1,z=0 → not taken. n=0,z=0 → taken. z=1 → not taken.
- jal 0x0C000010: JUMP gives `alu_op`=C, `alu_src_b`=5, `reg_dst`=2, `reg_write`=1, `pc_src`=2.
- Opcode 0x3F: `illegal` is a single-cycle pulse in DECODE, then FETCH. Separately, `reset_n` asserted during MEM of sw: `mem_wr` drops immediately and state returns to FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the MIPS multi-cycle control FSM
package mips_ctrl_pkg;

    // ALU opcodes
    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_AND   = 4'h2;
    localparam logic [3:0] ALU_OR    = 4'h3;
    localparam logic [3:0] ALU_XOR   = 4'h4;
    localparam logic [3:0] ALU_NOR   = 4'h5;
    localparam logic [3:0] ALU_SLL   = 4'h6;
    localparam logic [3:0] ALU_SRL   = 4'h7;
    localparam logic [3:0] ALU_SRA   = 4'h8;
    localparam logic [3:0] ALU_SLT   = 4'h9;
    localparam logic [3:0] ALU_PASSA = 4'hA;
    localparam logic [3:0] ALU_PASSB = 4'hB;
    localparam logic [3:0] ALU_B8    = 4'hC;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Operand A select
    localparam logic [1:0] SRCA_RS   = 2'd0;
    localparam logic [1:0] SRCA_RT   = 2'd1;
    localparam logic [1:0] SRCA_IMMZ = 2'd2;

    // Operand B select
    localparam logic [2:0] SRCB_RT    = 3'd0;
    localparam logic [2:0] SRCB_IMMS  = 3'd1;
    localparam logic [2:0] SRCB_IMMZ  = 3'd2;
    localparam logic [2:0] SRCB_SHAMT = 3'd3;
    localparam logic [2:0] SRCB_C16   = 3'd4;
    localparam logic [2:0] SRCB_PC    = 3'd5;

    // PC source
    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

    // Destination register
    localparam logic [1:0] DST_RT  = 2'd0;
    localparam logic [1:0] DST_RD  = 2'd1;
    localparam logic [1:0] DST_R31 = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_BRANCH = 3'd5,
        ST_JUMP   = 3'd6
    } state_t;

endpackage

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - maps opcode/funct of ALU-class instructions to ALU op and operand selects
module alu_op_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [2:0] alu_src_b,
    output logic       legal
);

    // legal covers only instructions that run through EXEC; branches and jumps are classified by the FSM
    always_comb begin
        alu_op    = ALU_ADD;
        alu_src_a = SRCA_RS;
        alu_src_b = SRCB_RT;
        legal     = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT, FN_SLTU: alu_op = ALU_SLT;
                    FN_SLL, FN_SRL, FN_SRA: begin
                        alu_op    = (funct == FN_SLL) ? ALU_SLL :
                                    (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
                        alu_src_a = SRCA_RT;
                        alu_src_b = SRCB_SHAMT;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
                alu_op    = ALU_ADD;
                alu_src_b = SRCB_IMMS;
            end
            OP_SLTI, OP_SLTIU: begin
                alu_op    = ALU_SLT;
                alu_src_b = SRCB_IMMS;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                alu_op    = (opcode == OP_ANDI) ? ALU_AND :
                            (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
                alu_src_b = SRCB_IMMZ;
            end
            OP_LUI: begin
                // lui is imm16 shifted left by the constant 16
                alu_op    = ALU_SLL;
                alu_src_a = SRCA_IMMZ;
                alu_src_b = SRCB_C16;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - multi-cycle MIPS control FSM driving datapath strobes and ALU controls
module mips_mc_control
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        z,
    input  logic        n,
    output logic [3:0]  alu_op,
    output logic [1:0]  alu_src_a,
    output logic [2:0]  alu_src_b,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic [2:0]  state
);

    state_t     state_q;
    logic [5:0] opcode_q;
    logic [5:0] funct_q;
    logic [4:0] rt_q;

    logic [3:0] dec_alu_op;
    logic [1:0] dec_src_a;
    logic [2:0] dec_src_b;
    logic       dec_legal;

    logic is_rtype, is_jr, is_link, is_jump, is_branch, is_mem, is_lw, is_sw;
    logic taken;
    logic fetch_go;

    // rs, imm16 and rt are consumed by the datapath, not by control
    logic unused_bits;
    assign unused_bits = ^{instr[25:21], instr[15:6], rt_q};

    alu_op_decoder u_dec (
        .opcode    (opcode_q),
        .funct     (funct_q),
        .alu_op    (dec_alu_op),
        .alu_src_a (dec_src_a),
        .alu_src_b (dec_src_b),
        .legal     (dec_legal)
    );

    assign is_rtype  = (opcode_q == OP_RTYPE);
    assign is_jr     = is_rtype && ((funct_q == FN_JR) || (funct_q == FN_JALR));
    assign is_link   = (opcode_q == OP_JAL) || (is_rtype && (funct_q == FN_JALR));
    assign is_jump   = (opcode_q == OP_J) || (opcode_q == OP_JAL) || is_jr;
    assign is_branch = (opcode_q == OP_BEQ) || (opcode_q == OP_BNE) ||
                       (opcode_q == OP_BLEZ) || (opcode_q == OP_BGTZ);
    assign is_lw     = (opcode_q == OP_LW);
    assign is_sw     = (opcode_q == OP_SW);
    assign is_mem    = is_lw || is_sw;

    // Gating with reset_n keeps write strobes quiet while reset is held in FETCH
    assign fetch_go  = (state_q == ST_FETCH) && mem_ready && reset_n;
    assign state     = state_q;

    // Branch condition from the ALU flags produced this cycle
    always_comb begin
        taken = 1'b0;
        case (opcode_q)
            OP_BEQ:  taken = z;
            OP_BNE:  taken = !z;
            OP_BLEZ: taken = z | n;
            OP_BGTZ: taken = !z & !n;
            default: taken = 1'b0;
        endcase
    end

    // State register and instruction field latches
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_FETCH;
            opcode_q <= 6'd0;
            funct_q  <= 6'd0;
            rt_q     <= 5'd0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (mem_ready) begin
                        opcode_q <= instr[31:26];
                        funct_q  <= instr[5:0];
                        rt_q     <= instr[20:16];
                        state_q  <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (is_branch)      state_q <= ST_BRANCH;
                    else if (is_jump)   state_q <= ST_JUMP;
                    else if (dec_legal) state_q <= ST_EXEC;
                    else                state_q <= ST_FETCH;
                end
                ST_EXEC:   state_q <= is_mem ? ST_MEM : ST_WB;
                ST_MEM: begin
                    if (mem_ready) state_q <= is_lw ? ST_WB : ST_FETCH;
                end
                default:   state_q <= ST_FETCH;
            endcase
        end
    end

    // Moore strobe decode from state and latched fields, plus same-cycle mem_ready/flag qualification
    always_comb begin
        alu_op     = ALU_ADD;
        alu_src_a  = SRCA_RS;
        alu_src_b  = SRCB_RT;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_PLUS4;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = DST_RT;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_rd = 1'b1;
                if (fetch_go) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_PLUS4;
                end
            end
            ST_DECODE: illegal = !(is_branch || is_jump || dec_legal);
            ST_EXEC: begin
                alu_op    = dec_alu_op;
                alu_src_a = dec_src_a;
                alu_src_b = dec_src_b;
            end
            ST_MEM: begin
                mem_rd = is_lw;
                mem_wr = is_sw;
            end
            ST_WB: begin
                alu_op     = dec_alu_op;
                alu_src_a  = dec_src_a;
                alu_src_b  = dec_src_b;
                reg_write  = 1'b1;
                reg_dst    = is_rtype ? DST_RD : DST_RT;
                mem_to_reg = is_lw;
            end
            ST_BRANCH: begin
                alu_op = ((opcode_q == OP_BEQ) || (opcode_q == OP_BNE)) ? ALU_SUB : ALU_PASSA;
                if (taken) begin
                    pc_write = 1'b1;
                    pc_src   = PC_BRANCH;
                end
            end
            ST_JUMP: begin
                pc_write = 1'b1;
                pc_src   = is_jr ? PC_RS : PC_JUMP;
                if (is_link) begin
                    alu_op    = ALU_B8;
                    alu_src_b = SRCB_PC;
                    reg_write = 1'b1;
                    reg_dst   = (opcode_q == OP_JAL) ? DST_R31 : DST_RD;
                end
            end
            default: ;
        endcase
    end

endmodule
